tm_qm_assoc_lookup: RTL and testbench
=====================================

# tm_qm_assoc_lookup

First-level enqueue front end of the traffic-manager queue manager, directly upstream of the first-level queue association memory. It accepts enqueue requests tagged with a first-level queue ID and issues one association read per request to the memory. It pairs each returned association with the descriptor that caused it and presents the results in arrival order to the second-level enqueue logic. An in-order context buffer absorbs memory read latency, including latency stretched by `clk_div`, and provides backpressure.

## Interface
Parameters:
- DESC_NBITS, 32, width of the opaque descriptor carried with each request
- DEPTH, 4, context buffer entries; must be a power of two, ≥2

Ports:
- clk  in  1  core clock
- `RESET_SIG`  in  1  reset; asynchronous, active-low
- enq_req  in  1  enqueue request valid
- enq_qid  in  `FIRST_LVL_QUEUE_ID_NBITS`  first-level queue ID
- enq_desc  in  DESC_NBITS  descriptor
- enq_ready  out  1  request accepted when enq_req && enq_ready
- queue_association_rd  out  1  single-cycle read strobe to the association memory
- queue_association_raddr  out  `FIRST_LVL_QUEUE_ID_NBITS`  read address
- queue_association_ack  in  1  read data valid; one per strobe, in order
- queue_association_rdata  in  `QUEUE_ASSOCIATION_NBITS`  association word
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_qid  out  `FIRST_LVL_QUEUE_ID_NBITS`  original queue ID
- out_assoc  out  `QUEUE_ASSOCIATION_NBITS`  association word
- out_desc  out  DESC_NBITS  original descriptor
- lookup_cnt  out  16  completed-lookup counter (stats build only)
- assoc_err  out  1  sticky unexpected-ack flag (stats build only)

## Operation
- Context buffer: DEPTH entries of {qid, desc, assoc}.
- Three pointers, each log2(DEPTH)+1 bits with a wrap bit: wr_ptr, ack_ptr, rd_ptr.
- Accept: write {enq_qid, enq_desc} at wr_ptr, then wr_ptr++.
- Registered read issue:
  - queue_association_rd = 1 in the following cycle.
  - queue_association_raddr = captured qid in that same cycle.
  - Back-to-back accepts produce back-to-back strobes.
- Ack: write rdata to entry[ack_ptr].assoc, then ack_ptr++.
- Output: out_valid = (rd_ptr != ack_ptr). Output fields are read from entry[rd_ptr]. out_valid && out_ready increments rd_ptr.
- enq_ready = (wr_ptr − rd_ptr) < DEPTH, combinational from the pointers.
- Full: enq_req held high while enq_ready = 0 is neither consumed nor written.
- Unexpected ack: an ack arriving while ack_ptr == wr_ptr (no outstanding reads) does not move ack_ptr. Its data is dropped and assoc_err is set.
- Simultaneous events:
  - Accept + pop in the same cycle: occupancy unchanged.
  - Ack + pop of an older entry: both take effect.
  - Ack for entry k and pop of entry k cannot coincide, because out_valid for k requires the ack to be registered first.
- Wrap-around: all pointer arithmetic is modulo 2·DEPTH. Full = MSBs differ and LSBs equal.
- Reset mid-operation clears all pointers. Outstanding memory reads are abandoned, and their acks after reset count as unexpected.

## Timing
- Reset values: enq_ready = 1; queue_association_rd = 0; queue_association_raddr = 0; out_valid = 0; out_qid, out_assoc, out_desc = 0; lookup_cnt = 0; assoc_err = 0.
- Accept in cycle N → queue_association_rd high in cycle N+1.
- Ack in cycle M → out_valid high in cycle M+1 if that entry is at the head.
- Minimum request-to-result latency is 3 cycles when the memory acks one cycle after the strobe.
- While out_valid = 1 and out_ready = 0, all out_* fields are held stable.
- Throughput is one request per cycle while the buffer is not full and the memory acks one per cycle.
- An entry frees on pop. enq_ready rises in the cycle after the pop.

## Configuration
- TM_QM_ASSOC_STATS_EN defined:
  - lookup_cnt increments on each valid ack and saturates at 16'hFFFF.
  - assoc_err is set by an unexpected ack and cleared only by reset.
- TM_QM_ASSOC_STATS_EN undefined:
  - lookup_cnt and assoc_err are tied to 0 and no counter logic is built.
  - The unexpected ack is still ignored.

## Test plan
- Single request: qid=5, desc=32'hA5A5_0001; memory acks 2 cycles after the strobe with rdata=0x3C. Required: raddr=5 one cycle after accept; out_valid with {5, 0x3C, A5A5_0001}; lookup_cnt=1.
- Burst of 6 requests, DEPTH=4, out_ready=0:
  - enq_ready falls after 4 accepts.
  - Exactly 4 read strobes are issued.
  - Raising out_ready drains results in order, after which the remaining 2 requests are accepted and read.
- Variable latency: acks returned with gaps of 1, 5 and 3 cycles. Required: out_qid and out_assoc pairing is preserved and outputs stay stable under out_ready toggling.
- Wrap-around: stream 20 requests (qid = 0..19) with one-cycle acks and out_ready=1. Required: no stall after the first fill, results in order, lookup_cnt=20.
- Unexpected ack with an empty buffer. Required: assoc_err=1, pointers unchanged, a subsequent normal request completes correctly.
- Reset asserted with 2 reads outstanding. Required: out_valid=0 and enq_ready=1 immediately; late acks set assoc_err in the stats build.

Source files
------------

// File: rtl/tm_qm_assoc_lookup.sv
// tm_qm_assoc_lookup: first-level enqueue front end pairing association-memory reads with their descriptors, in order.
// Optional statistics (lookup_cnt, assoc_err) are built when TM_QM_ASSOC_STATS_EN is defined.
`timescale 1ns/1ps
`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef QUEUE_ASSOCIATION_NBITS
`define QUEUE_ASSOCIATION_NBITS 16
`endif
module tm_qm_assoc_lookup #(
   parameter int DESC_NBITS = 32,
   parameter int DEPTH      = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  enq_req,
   input  logic [`FIRST_LVL_QUEUE_ID_NBITS-1:0]  enq_qid,
   input  logic [DESC_NBITS-1:0]                 enq_desc,
   output logic                                  enq_ready,
   output logic                                  queue_association_rd,
   output logic [`FIRST_LVL_QUEUE_ID_NBITS-1:0]  queue_association_raddr,
   input  logic                                  queue_association_ack,
   input  logic [`QUEUE_ASSOCIATION_NBITS-1:0]   queue_association_rdata,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [`FIRST_LVL_QUEUE_ID_NBITS-1:0]  out_qid,
   output logic [`QUEUE_ASSOCIATION_NBITS-1:0]   out_assoc,
   output logic [DESC_NBITS-1:0]                 out_desc,
   output logic [15:0]                           lookup_cnt,
   output logic                                  assoc_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int QW = `FIRST_LVL_QUEUE_ID_NBITS;
   localparam int SW = `QUEUE_ASSOCIATION_NBITS;
   logic [QW-1:0]         qid_mem   [DEPTH];
   logic [DESC_NBITS-1:0] desc_mem  [DEPTH];
   logic [SW-1:0]         assoc_mem [DEPTH];
   logic [AW:0]           wr_ptr, ack_ptr, rd_ptr;
   logic                  accept, ack_ok, pop;
   assign enq_ready = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
   assign accept    = enq_req && enq_ready;
   assign ack_ok    = queue_association_ack && (ack_ptr != wr_ptr);
   assign out_valid = rd_ptr != ack_ptr;
   assign pop       = out_valid && out_ready;
   assign out_qid   = out_valid ? qid_mem[rd_ptr[AW-1:0]] : '0;
   assign out_assoc = out_valid ? assoc_mem[rd_ptr[AW-1:0]] : '0;
   assign out_desc  = out_valid ? desc_mem[rd_ptr[AW-1:0]] : '0;
   // pointer advance and registered read strobe toward the association memory
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr                  <= '0;
         ack_ptr                 <= '0;
         rd_ptr                  <= '0;
         queue_association_rd    <= 1'b0;
         queue_association_raddr <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (ack_ok) ack_ptr <= ack_ptr + (AW+1)'(1);
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
         queue_association_rd <= accept;
         if (accept) queue_association_raddr <= enq_qid;
      end
   end
   // context storage; unread entries are masked at the outputs so no reset is needed
   always_ff @(posedge clk) begin
      if (accept) begin
         qid_mem[wr_ptr[AW-1:0]]  <= enq_qid;
         desc_mem[wr_ptr[AW-1:0]] <= enq_desc;
      end
      if (ack_ok) assoc_mem[ack_ptr[AW-1:0]] <= queue_association_rdata;
   end
`ifdef TM_QM_ASSOC_STATS_EN
   // saturating completed-lookup count and sticky flag for acks with nothing outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lookup_cnt <= '0;
         assoc_err  <= 1'b0;
      end else begin
         if (ack_ok && lookup_cnt != 16'hFFFF) lookup_cnt <= lookup_cnt + 16'd1;
         if (queue_association_ack && !ack_ok) assoc_err <= 1'b1;
      end
   end
`else
   assign lookup_cnt = '0;
   assign assoc_err  = 1'b0;
`endif
endmodule

// File: tb/tb_tm_qm_assoc_lookup.sv
// tb_tm_qm_assoc_lookup: directed bench with an in-order association-memory model and an output scoreboard.
`timescale 1ns/1ps
`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef QUEUE_ASSOCIATION_NBITS
`define QUEUE_ASSOCIATION_NBITS 16
`endif
module tb_tm_qm_assoc_lookup;
   localparam int DW = 32;
   localparam int QW = `FIRST_LVL_QUEUE_ID_NBITS;
   localparam int SW = `QUEUE_ASSOCIATION_NBITS;
`ifdef TM_QM_ASSOC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enq_req = 1'b0;
   logic [QW-1:0] enq_qid = '0;
   logic [DW-1:0] enq_desc = '0;
   logic          enq_ready;
   logic          queue_association_rd;
   logic [QW-1:0] queue_association_raddr;
   logic          queue_association_ack = 1'b0;
   logic [SW-1:0] queue_association_rdata = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [QW-1:0] out_qid;
   logic [SW-1:0] out_assoc;
   logic [DW-1:0] out_desc;
   logic [15:0]   lookup_cnt;
   logic          assoc_err;

   always #5 clk = ~clk;

   tm_qm_assoc_lookup #(.DESC_NBITS(DW), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .enq_req(enq_req), .enq_qid(enq_qid), .enq_desc(enq_desc), .enq_ready(enq_ready),
      .queue_association_rd(queue_association_rd), .queue_association_raddr(queue_association_raddr),
      .queue_association_ack(queue_association_ack), .queue_association_rdata(queue_association_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_qid(out_qid), .out_assoc(out_assoc),
      .out_desc(out_desc), .lookup_cnt(lookup_cnt), .assoc_err(assoc_err)
   );

   int checks = 0;
   int errors = 0;
   typedef struct {logic [QW-1:0] qid; logic [DW-1:0] desc;} exp_t;
   typedef struct {logic [QW-1:0] qid; logic [DW-1:0] desc; int lat; logic [SW-1:0] assoc;} vec_t;
   exp_t exp_q[$];
   int   lat = 1;
   int   lat_q[$];
   int   inj_req = 0;
   int   nstrobe = 0;

   function automatic logic [SW-1:0] assoc_of(logic [QW-1:0] q);
      return SW'(q) + SW'(8'h37);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic enq(input logic [QW-1:0] q, input logic [DW-1:0] d);
      int n = 0;
      enq_req = 1'b1;
      enq_qid = q;
      enq_desc = d;
      while (!enq_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!enq_ready) begin
         enq_req = 1'b0;
         checks++;
         errors++;
         $display("FAIL enq_timeout: qid %0h never accepted", q);
      end else begin
         exp_q.push_back('{q, d});
         @(negedge clk);
         enq_req = 1'b0;
      end
   endtask

   task automatic drain(string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   // association memory: acks in order, per-strobe latency, plus injected stray acks
   initial begin : mem_model
      int ncyc = 0;
      int last_due = 0;
      int inj_done = 0;
      int due_q[$];
      logic [QW-1:0] addr_q[$];
      forever begin
         @(negedge clk);
         #1;
         ncyc++;
         queue_association_ack = 1'b0;
         if (inj_req != inj_done) begin
            inj_done++;
            queue_association_ack = 1'b1;
            queue_association_rdata = SW'(16'hDEAD);
         end else if (due_q.size() > 0 && due_q[0] <= ncyc) begin
            queue_association_ack = 1'b1;
            queue_association_rdata = assoc_of(addr_q[0]);
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
         end
         if (queue_association_rd) begin
            int l;
            int d;
            l = (lat_q.size() > 0) ? lat_q.pop_front() : lat;
            d = ncyc + l;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            due_q.push_back(d);
            addr_q.push_back(queue_association_raddr);
            nstrobe++;
         end
      end
   end

   // in-order result checking plus hold-stability while stalled
   initial begin : scoreboard
      logic stalled = 1'b0;
      logic [QW-1:0] sq;
      logic [SW-1:0] sa;
      logic [DW-1:0] sd;
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (stalled) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_qid", out_qid, sq);
            chk("hold_assoc", out_assoc, sa);
            chk("hold_desc", out_desc, sd);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_output: qid %0h with nothing expected", out_qid);
            end else begin
               e = exp_q.pop_front();
               chk("sb_qid", out_qid, e.qid);
               chk("sb_assoc", out_assoc, assoc_of(e.qid));
               chk("sb_desc", out_desc, e.desc);
            end
         end
         stalled = out_valid && !out_ready;
         sq = out_qid;
         sa = out_assoc;
         sd = out_desc;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t     vt[4];
      logic [15:0] cnt0;
      longint   t0;
      int       base;
      int       n;
      vt[0] = '{QW'(5),     32'hA5A5_0001, 2, SW'(16'h003C)};
      vt[1] = '{QW'(0),     32'h0000_0000, 1, SW'(16'h0037)};
      vt[2] = '{QW'(8'hFF), 32'hFFFF_FFFF, 3, SW'(16'h0136)};
      vt[3] = '{QW'(8'h2A), 32'h1234_5678, 1, SW'(16'h0061)};
      repeat (2) @(negedge clk);
      chk("rst_enq_ready", enq_ready, 1);
      chk("rst_rd", queue_association_rd, 0);
      chk("rst_raddr", queue_association_raddr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_qid", out_qid, 0);
      chk("rst_out_assoc", out_assoc, 0);
      chk("rst_out_desc", out_desc, 0);
      chk("rst_lookup_cnt", lookup_cnt, 0);
      chk("rst_assoc_err", assoc_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         lat = vt[i].lat;
         enq(vt[i].qid, vt[i].desc);
         chk("vec_rd", queue_association_rd, 1);
         chk("vec_raddr", queue_association_raddr, vt[i].qid);
         n = 0;
         while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("vec_latency", n, vt[i].lat + 1);
         chk("vec_qid", out_qid, vt[i].qid);
         chk("vec_assoc", out_assoc, vt[i].assoc);
         chk("vec_desc", out_desc, vt[i].desc);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk("vec_valid_after_pop", out_valid, 0);
         chk("vec_lookup_cnt", lookup_cnt, STATS ? 64'(i + 1) : 64'd0);
      end
      base = nstrobe;
      lat = 1;
      for (int i = 0; i < 4; i++) enq(QW'(8'h10 + i), 32'hB000_0000 + i);
      chk("burst_full", enq_ready, 0);
      fork
         enq(QW'(8'h14), 32'hB000_0004);
         begin
            repeat (6) @(negedge clk);
            chk("burst_strobes_full", nstrobe - base, 4);
            chk("burst_hold_ready", enq_ready, 0);
            out_ready = 1'b1;
            @(negedge clk);
            chk("burst_ready_after_pop", enq_ready, 1);
         end
      join
      enq(QW'(8'h15), 32'hB000_0005);
      drain("burst_drain");
      chk("burst_strobes_all", nstrobe - base, 6);
      lat_q.push_back(1);
      lat_q.push_back(5);
      lat_q.push_back(3);
      fork
         for (int i = 0; i < 3; i++) enq(QW'(8'h40 + i), 32'hC0DE_0000 + i);
         for (int k = 0; k < 16; k++) begin
            out_ready = k[0];
            @(negedge clk);
         end
      join
      out_ready = 1'b1;
      drain("varlat_drain");
      cnt0 = lookup_cnt;
      lat = 1;
      t0 = $time;
      for (int i = 0; i < 20; i++) enq(QW'(i), 32'hD000_0000 + i);
      chk("wrap_no_stall", ($time - t0) / 10, 20);
      drain("wrap_drain");
      chk("wrap_lookup_cnt", lookup_cnt - cnt0, STATS ? 64'd20 : 64'd0);
      cnt0 = lookup_cnt;
      inj_req++;
      repeat (3) @(negedge clk);
      chk("unexp_err", assoc_err, STATS);
      chk("unexp_valid", out_valid, 0);
      chk("unexp_ready", enq_ready, 1);
      chk("unexp_cnt", lookup_cnt, cnt0);
      enq(QW'(7), 32'h0777_0007);
      drain("unexp_drain");
      chk("unexp_post_cnt", lookup_cnt - cnt0, STATS);
      lat = 4;
      enq(QW'(8'h21), 32'hE000_0021);
      enq(QW'(8'h22), 32'hE000_0022);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", enq_ready, 1);
      chk("mid_rst_rd", queue_association_rd, 0);
      chk("mid_rst_err", assoc_err, 0);
      chk("mid_rst_cnt", lookup_cnt, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("late_ack_err", assoc_err, STATS);
      chk("late_ack_valid", out_valid, 0);
      chk("late_ack_cnt", lookup_cnt, 0);
      lat = 1;
      enq(QW'(8'h33), 32'hE000_0033);
      drain("post_rst_drain");
      chk("post_rst_cnt", lookup_cnt, STATS);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
